// File: rtl/ysyx_22050612_wbu.sv
// Write-back unit: arbitrates EXU/LSU results into one register-file write port with operand bypass.
// Optional feature macro: YSYX_22050612_WBU_COMMIT_CNT_EN enables the 64-bit commit counter.
//
// state | meaning
// IDLE  | no register-file write this cycle (rf_wen=0)
// WRITE | write of the request accepted last cycle in progress (rf_wen=1)

module ysyx_22050612_wbu #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  exu_valid,
   output logic                  exu_ready,
   input  logic                  exu_wen,
   input  logic [ADDR_WIDTH-1:0] exu_rd,
   input  logic [DATA_WIDTH-1:0] exu_data,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic                  lsu_wen,
   input  logic [ADDR_WIDTH-1:0] lsu_rd,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   input  logic [2:0]            lsu_funct3,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   input  logic [ADDR_WIDTH-1:0] q_rs,
   output logic                  q_hit,
   output logic [DATA_WIDTH-1:0] q_data,
   output logic [63:0]           commit_cnt
);

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic                    lsu_fire;
   logic                    exu_fire;
   logic                    fire;
   logic                    sel_wen;
   logic [ADDR_WIDTH-1:0]   sel_rd;
   logic [DATA_WIDTH-1:0]   sel_data;
   logic [DATA_WIDTH-1:0]   lsu_ext;

   // LSU always wins; EXU simply holds its request while LSU is valid.
   assign lsu_ready = ~rst;
   assign exu_ready = ~rst & ~lsu_valid;
   assign lsu_fire  = lsu_valid & lsu_ready;
   assign exu_fire  = exu_valid & exu_ready;
   assign fire      = lsu_fire | exu_fire;

   always_comb begin
      lsu_ext = lsu_data;
      case (lsu_funct3)
         3'b000:  lsu_ext = {{(DATA_WIDTH-8){lsu_data[7]}},   lsu_data[7:0]};
         3'b001:  lsu_ext = {{(DATA_WIDTH-16){lsu_data[15]}}, lsu_data[15:0]};
         3'b010:  lsu_ext = {{(DATA_WIDTH-32){lsu_data[31]}}, lsu_data[31:0]};
         3'b100:  lsu_ext = {{(DATA_WIDTH-8){1'b0}},          lsu_data[7:0]};
         3'b101:  lsu_ext = {{(DATA_WIDTH-16){1'b0}},         lsu_data[15:0]};
         3'b110:  lsu_ext = {{(DATA_WIDTH-32){1'b0}},         lsu_data[31:0]};
         default: lsu_ext = lsu_data;
      endcase
   end

   always_comb begin
      sel_wen  = exu_wen;
      sel_rd   = exu_rd;
      sel_data = exu_data;
      if (lsu_fire) begin
         sel_wen  = lsu_wen;
         sel_rd   = lsu_rd;
         sel_data = lsu_ext;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // x0 writes are accepted and counted but never raise rf_wen.
   always_comb begin
      state_nxt = IDLE;
      rf_wen    = 1'b0;
      if (fire && sel_wen && (sel_rd != '0)) begin
         state_nxt = WRITE;
      end
      if (state == WRITE) begin
         rf_wen = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else if (fire) begin
         rf_waddr <= sel_rd;
         rf_wdata <= sel_data;
      end
   end

   assign q_hit  = rf_wen & (rf_waddr == q_rs) & (q_rs != '0);
   assign q_data = q_hit ? rf_wdata : '0;

`ifdef YSYX_22050612_WBU_COMMIT_CNT_EN
   logic [63:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (fire) begin
         cnt <= cnt + 64'd1;
      end
   end

   assign commit_cnt = cnt;
`else
   assign commit_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_22050612_wbu.sv
// Directed self-checking bench for ysyx_22050612_wbu; expected commit count follows
// YSYX_22050612_WBU_COMMIT_CNT_EN.

module tb_ysyx_22050612_wbu;

   logic        clk;
   logic        rst;
   logic        exu_valid;
   logic        exu_ready;
   logic        exu_wen;
   logic [4:0]  exu_rd;
   logic [63:0] exu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic        lsu_wen;
   logic [4:0]  lsu_rd;
   logic [63:0] lsu_data;
   logic [2:0]  lsu_funct3;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [63:0] rf_wdata;
   logic [4:0]  q_rs;
   logic        q_hit;
   logic [63:0] q_data;
   logic [63:0] commit_cnt;

   int          checks;
   int          errors;
   logic [63:0] transfers;

   ysyx_22050612_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .exu_valid  (exu_valid),
      .exu_ready  (exu_ready),
      .exu_wen    (exu_wen),
      .exu_rd     (exu_rd),
      .exu_data   (exu_data),
      .lsu_valid  (lsu_valid),
      .lsu_ready  (lsu_ready),
      .lsu_wen    (lsu_wen),
      .lsu_rd     (lsu_rd),
      .lsu_data   (lsu_data),
      .lsu_funct3 (lsu_funct3),
      .rf_wen     (rf_wen),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .q_rs       (q_rs),
      .q_hit      (q_hit),
      .q_data     (q_data),
      .commit_cnt (commit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] exp_cnt();
`ifdef YSYX_22050612_WBU_COMMIT_CNT_EN
      return transfers;
`else
      return 64'd0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      exu_valid  = 1'b0;
      exu_wen    = 1'b0;
      exu_rd     = 5'd0;
      exu_data   = 64'd0;
      lsu_valid  = 1'b0;
      lsu_wen    = 1'b0;
      lsu_rd     = 5'd0;
      lsu_data   = 64'd0;
      lsu_funct3 = 3'd0;
   endtask

   task automatic lsu_case(input string tag, input logic [2:0] f3, input logic [63:0] data,
                           input logic [63:0] exp);
      lsu_valid  = 1'b1;
      lsu_wen    = 1'b1;
      lsu_rd     = 5'd3;
      lsu_data   = data;
      lsu_funct3 = f3;
      tick();
      transfers++;
      check(tag, rf_wdata, exp);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      transfers = 64'd0;
      rst       = 1'b1;
      q_rs      = 5'd0;
      idle_inputs();

      // reset state
      #12;
      check("rst_rf_wen",    {63'd0, rf_wen},    64'd0);
      check("rst_rf_waddr",  {59'd0, rf_waddr},  64'd0);
      check("rst_rf_wdata",  rf_wdata,           64'd0);
      check("rst_cnt",       commit_cnt,         64'd0);
      check("rst_lsu_ready", {63'd0, lsu_ready}, 64'd0);
      check("rst_exu_ready", {63'd0, exu_ready}, 64'd0);

      // first transfer right after reset release
      @(negedge clk);
      rst       = 1'b0;
      exu_valid = 1'b1;
      exu_wen   = 1'b1;
      exu_rd    = 5'd5;
      exu_data  = 64'h1234;
      #1;
      check("rdy_lsu", {63'd0, lsu_ready}, 64'd1);
      check("rdy_exu", {63'd0, exu_ready}, 64'd1);
      tick();
      transfers++;
      check("exu_wen",   {63'd0, rf_wen},   64'd1);
      check("exu_waddr", {59'd0, rf_waddr}, 64'd5);
      check("exu_wdata", rf_wdata,          64'h1234);
      check("exu_cnt",   commit_cnt,        exp_cnt());
      idle_inputs();
      tick();
      check("exu_wen_off",  {63'd0, rf_wen},   64'd0);
      check("exu_hold_adr", {59'd0, rf_waddr}, 64'd5);
      check("exu_hold_dat", rf_wdata,          64'h1234);

      // load extension
      lsu_case("ext_lb",  3'b000, 64'h80,                 64'hFFFF_FFFF_FFFF_FF80);
      check("ext_lb_adr", {59'd0, rf_waddr}, 64'd3);
      lsu_case("ext_lbu", 3'b100, 64'h80,                 64'h0000_0000_0000_0080);
      lsu_case("ext_lh",  3'b001, 64'h1234_5678_9ABC_8001, 64'hFFFF_FFFF_FFFF_8001);
      lsu_case("ext_lw",  3'b010, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF_8000_0000);
      lsu_case("ext_ld",  3'b011, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF);
      lsu_case("ext_lhu", 3'b101, 64'hFFFF_FFFF_FFFF_8001, 64'h0000_0000_0000_8001);
      lsu_case("ext_lwu", 3'b110, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000);
      lsu_case("ext_111", 3'b111, 64'hDEAD_BEEF_0000_00FF, 64'hDEAD_BEEF_0000_00FF);
      lsu_case("ext_lw_pos", 3'b010, 64'hFFFF_FFFF_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF);
      check("ext_cnt", commit_cnt, exp_cnt());
      idle_inputs();
      tick();

      // both channels valid: LSU first, EXU next, no bubble
      lsu_valid  = 1'b1;
      lsu_wen    = 1'b1;
      lsu_rd     = 5'd1;
      lsu_data   = 64'h1111;
      lsu_funct3 = 3'b011;
      exu_valid  = 1'b1;
      exu_wen    = 1'b1;
      exu_rd     = 5'd2;
      exu_data   = 64'h2222;
      #1;
      check("arb_exu_ready", {63'd0, exu_ready}, 64'd0);
      tick();
      transfers++;
      check("arb_wen1",   {63'd0, rf_wen},   64'd1);
      check("arb_waddr1", {59'd0, rf_waddr}, 64'd1);
      check("arb_wdata1", rf_wdata,          64'h1111);
      lsu_valid = 1'b0;
      #1;
      check("arb_exu_ready2", {63'd0, exu_ready}, 64'd1);
      tick();
      transfers++;
      check("arb_wen2",   {63'd0, rf_wen},   64'd1);
      check("arb_waddr2", {59'd0, rf_waddr}, 64'd2);
      check("arb_wdata2", rf_wdata,          64'h2222);
      idle_inputs();
      tick();
      check("arb_wen_off", {63'd0, rf_wen}, 64'd0);

      // x0 write dropped but counted; wen=0 dropped
      exu_valid = 1'b1;
      exu_wen   = 1'b1;
      exu_rd    = 5'd0;
      exu_data  = 64'h5555;
      tick();
      transfers++;
      check("x0_wen", {63'd0, rf_wen}, 64'd0);
      check("x0_cnt", commit_cnt,      exp_cnt());
      exu_wen = 1'b0;
      exu_rd  = 5'd4;
      tick();
      transfers++;
      check("nowen_wen", {63'd0, rf_wen}, 64'd0);
      check("nowen_cnt", commit_cnt,      exp_cnt());

      // bypass lookup
      exu_wen  = 1'b1;
      exu_rd   = 5'd7;
      exu_data = 64'hAA;
      tick();
      transfers++;
      exu_valid = 1'b0;
      q_rs      = 5'd7;
      #1;
      check("q_hit7",  {63'd0, q_hit}, 64'd1);
      check("q_data7", q_data,         64'hAA);
      q_rs = 5'd8;
      #1;
      check("q_hit8",  {63'd0, q_hit}, 64'd0);
      check("q_data8", q_data,         64'd0);
      q_rs = 5'd0;
      #1;
      check("q_hit0", {63'd0, q_hit}, 64'd0);
      tick();
      q_rs = 5'd7;
      #1;
      check("q_hit_idle", {63'd0, q_hit}, 64'd0);

      // async reset during a WRITE cycle
      exu_valid = 1'b1;
      exu_wen   = 1'b1;
      exu_rd    = 5'd9;
      exu_data  = 64'h9999;
      tick();
      transfers++;
      check("mid_wen_pre", {63'd0, rf_wen}, 64'd1);
      rst = 1'b1;
      #1;
      transfers = 64'd0;
      check("mid_wen",    {63'd0, rf_wen},    64'd0);
      check("mid_waddr",  {59'd0, rf_waddr},  64'd0);
      check("mid_wdata",  rf_wdata,           64'd0);
      check("mid_cnt",    commit_cnt,         64'd0);
      check("mid_q_hit",  {63'd0, q_hit},     64'd0);
      check("mid_lsu_rdy", {63'd0, lsu_ready}, 64'd0);
      check("mid_exu_rdy", {63'd0, exu_ready}, 64'd0);
      tick();
      check("rst_hold_wen", {63'd0, rf_wen}, 64'd0);

      // release and take the held request at the first edge
      rst = 1'b0;
      tick();
      transfers++;
      check("post_wen",   {63'd0, rf_wen},   64'd1);
      check("post_waddr", {59'd0, rf_waddr}, 64'd9);
      check("post_cnt",   commit_cnt,        exp_cnt());
      idle_inputs();
      tick();
      check("post_wen_off", {63'd0, rf_wen}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
